// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync RAM between fetch and data; data wins unless fetch has waited FETCH_LIMIT grants.
// Grant in cycle N, result pulse in N+1; requests are level-held, so the losing requester simply stalls.
module mem_port_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int FETCH_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_addr_valid,
  output logic [DATA_W-1:0] imem_data,
  output logic              imem_data_valid,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_dout,
  input  logic              dmem_rstrobe,
  input  logic              dmem_wstrobe,
  output logic [DATA_W-1:0] dmem_din,
  output logic              dmem_cycle_complete,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ram_cs,
  output logic              ram_we
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(FETCH_LIMIT);

  state_t     state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       imem_data_valid_q, imem_data_valid_d;
  logic       dmem_cycle_complete_q, dmem_cycle_complete_d;

  logic data_req;
  logic fetch_starved;
  logic data_win;
  logic fetch_win;
  logic in_idle;

  always_comb begin
    data_req      = dmem_rstrobe | dmem_wstrobe;
    fetch_starved = imem_addr_valid && (streak_q == LIMIT);
    data_win      = data_req && !fetch_starved;
    fetch_win     = imem_addr_valid && !data_win;
    in_idle       = (state_q == IDLE);

    state_d               = state_q;
    streak_d              = streak_q;
    imem_data_valid_d     = 1'b0;
    dmem_cycle_complete_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_win) begin
          state_d               = D_WAIT;
          dmem_cycle_complete_d = 1'b1;
        end else if (fetch_win) begin
          state_d           = I_WAIT;
          imem_data_valid_d = 1'b1;
        end
        // Streak only grows while fetch is actually waiting; any fetch grant or fetch-idle cycle clears it.
        if (fetch_win || !imem_addr_valid) begin
          streak_d = 4'd0;
        end else if (data_win && (streak_q != LIMIT)) begin
          streak_d = streak_q + 4'd1;
        end
      end
      I_WAIT:  state_d = IDLE;
      D_WAIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q               <= IDLE;
      streak_q              <= 4'd0;
      imem_data_valid_q     <= 1'b0;
      dmem_cycle_complete_q <= 1'b0;
    end else begin
      state_q               <= state_d;
      streak_q              <= streak_d;
      imem_data_valid_q     <= imem_data_valid_d;
      dmem_cycle_complete_q <= dmem_cycle_complete_d;
    end
  end

  // Reset must silence the RAM and the result pulses within the same cycle it is asserted.
  assign ram_cs              = in_idle && !rst && (data_win || fetch_win);
  assign ram_we              = in_idle && !rst && data_win && dmem_wstrobe;
  assign ram_addr            = data_win ? dmem_addr : imem_addr;
  assign ram_din             = dmem_dout;
  assign imem_data           = ram_dout;
  assign dmem_din            = ram_dout;
  assign imem_data_valid     = imem_data_valid_q && !rst;
  assign dmem_cycle_complete = dmem_cycle_complete_q && !rst;

endmodule
